// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, golden table and table geometry.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_MASK = 16'hDF03;
  localparam int unsigned VEC_W       = 4;
  localparam int unsigned TABLE_DEPTH = 16;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter; reports zero and parks there until reloaded.
module settle_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives vectors 0..15 onto a 4-input datapath, samples F after a settle interval and
// compares the observed truth table against a golden minterm mask.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned            SETTLE_CYCLES = 1,
  parameter logic [TABLE_DEPTH-1:0] EXPECTED_MASK = DEFAULT_MASK
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         f_in,
  output logic [VEC_W-1:0]             vec_out,
  output logic                         busy,
  output logic                         done,
  output logic [TABLE_DEPTH-1:0]       table_out,
  output logic [$clog2(TABLE_DEPTH):0] mismatch_count,
  output logic [VEC_W-1:0]             first_fail,
  output logic                         first_fail_valid,
  output logic                         pass
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned MC_W  = $clog2(TABLE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(TABLE_DEPTH - 1);

  state_t state, state_next;

  logic            timer_load;
  logic            timer_zero;
  logic            last_vec;
  logic            sample_miss;
  logic            clear_results;
  logic [MC_W-1:0] mismatch_next;

  settle_timer #(
    .WIDTH(CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (RELOAD),
    .zero     (timer_zero)
  );

  assign busy          = (state == SETTLE) || (state == CAPTURE);
  assign done          = (state == DONE);
  assign last_vec      = (vec_out == LAST_VEC);
  assign sample_miss   = (f_in != EXPECTED_MASK[vec_out]);
  assign mismatch_next = mismatch_count + MC_W'(sample_miss);
  // start in IDLE wins over abort; abort only matters while a sweep is running
  assign clear_results = ((state == IDLE) && start) || (busy && abort);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (timer_zero) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_vec) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
          timer_load = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_out          <= '0;
      table_out        <= '0;
      mismatch_count   <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (clear_results) begin
      vec_out          <= '0;
      table_out        <= '0;
      mismatch_count   <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (state == CAPTURE) begin
      table_out[vec_out] <= f_in;
      if (sample_miss) begin
        mismatch_count <= mismatch_next;
        if (!first_fail_valid) begin
          first_fail       <= vec_out;
          first_fail_valid <= 1'b1;
        end
      end
      if (last_vec) begin
        pass <= (mismatch_next == '0);
      end else begin
        vec_out <= vec_out + VEC_W'(1);
      end
    end
  end

endmodule
